vend_ctrl_multi: RTL and testbench
==================================

Name: vend_ctrl_multi

Overview:
- Parametrised multi-product vending controller; successor to the 3-state, fixed-price coin FSM.
- Accumulates credit from three coin denominations and sells NUM_ITEMS products at a common PRICE.
- Tracks per-item stock, returns change, and supports cancel/refund.
- Sits between the coin acceptor/keypad front end and the dispense/change actuators.

Parameters:
- CREDIT_W, 8, width of credit and change values.
- NUM_ITEMS, 4, number of products; ID width IW = max(1, $clog2(NUM_ITEMS)).
- STOCK_W, 4, per-item stock counter width.
- STOCK_INIT, 8, stock of each item after reset.
- PRICE, 15, price of any item, in credit units.
- MAX_CREDIT, 95, credit ceiling; a coin that would exceed it is rejected.
- COIN1_VAL / COIN2_VAL / COIN3_VAL, 5 / 10 / 25, values for coin codes 1 / 2 / 3.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- coin_valid  in  1  coin present this cycle
- coin_code  in  2  0 = invalid, 1..3 = denomination
- sel_valid  in  1  product selection strobe
- sel_id  in  IW  selected product
- cancel  in  1  refund request
- coin_reject  out  1  1-cycle pulse: coin not accepted
- sel_nack  out  1  1-cycle pulse: selection refused
- vend_valid  out  1  1-cycle dispense pulse
- vend_id  out  IW  product dispensed; valid with vend_valid
- change_valid  out  1  1-cycle change pulse
- change_amt  out  CREDIT_W  amount returned; valid with change_valid
- credit  out  CREDIT_W  current credit
- sold_out  out  NUM_ITEMS  bit i = 1 when stock[i] == 0

Behaviour:
- Reset: state IDLE, credit 0, all pulses 0, vend_id 0, change_amt 0, every stock = STOCK_INIT, sold_out = 0. Reset mid-operation discards credit and emits no change.
- Registering: all outputs are registered, and sold_out is derived from the stock registers.
- States: IDLE (credit == 0), CREDIT (credit > 0), VEND, CHANGE.
- Input priority in IDLE/CREDIT, one event per cycle: cancel > sel_valid > coin_valid. An event sampled at edge N is reflected in the outputs at cycle N+1.
- Coin handling:
  - Accepted when coin_code != 0, credit + value <= MAX_CREDIT, and no cancel/sel in the same cycle. Credit increases next cycle and the state becomes CREDIT.
  - Otherwise coin_reject pulses for one cycle and credit is unchanged.
  - coin_valid while in VEND or CHANGE -> coin_reject.
- Select handling:
  - Success requires credit >= PRICE and stock[sel_id] > 0 (sel_id < NUM_ITEMS). Then the state goes to VEND, credit -= PRICE, stock[sel_id] decrements, and in VEND vend_valid = 1 with vend_id = sel_id.
  - Failure: sel_nack pulses and the state is unchanged. This includes selecting from IDLE and an out-of-range sel_id.
  - sel_valid while in VEND or CHANGE is ignored with no nack.
- Cancel:
  - Cancel in CREDIT goes to CHANGE.
  - Cancel in IDLE does nothing.
  - Cancel in VEND or CHANGE is ignored.
- VEND lasts 1 cycle, then:
  - remaining credit > 0 -> CHANGE;
  - remaining credit == 0 -> IDLE.
- CHANGE lasts 1 cycle: change_valid = 1, change_amt = credit at entry, credit reads 0 in this cycle, then IDLE.
- Timing: select at edge N -> vend_valid at N+1 -> change_valid at N+2 -> IDLE at N+3.
- Stock saturates at 0 and never wraps; a sold-out item is refused.
- Arithmetic: credit arithmetic is unsigned CREDIT_W bits. Elaboration requires MAX_CREDIT < 2^CREDIT_W and PRICE <= MAX_CREDIT.

Optional Feature:
- Macro: VEND_MULTI_CREDIT_EN.
- Defined: after VEND with remaining credit > 0, the state returns to CREDIT with credit kept, so further selections are possible. Change is paid only on cancel.
- Undefined: remaining credit is always refunded via CHANGE as described above.

Test Plan:
- Reset, then coins 10, 5, then select item 2 -> credit 10 then 15; vend_valid with vend_id 2 two cycles later; no change_valid; stock[2] = 7; back in IDLE.
- Coin 25, select item 0 -> vend_valid, next cycle change_valid with change_amt 10, then credit 0.
- Coins 25, 25, 25, 25 (MAX_CREDIT 95) -> credit 75, then coin_reject on the 4th coin; cancel -> change_amt 75.
- Drain item 1 (8 sales) -> sold_out[1] = 1; 9th select with credit 15 -> sel_nack and credit stays 15.
- Same cycle coin 10 + sel_valid with credit 15 -> vend occurs and coin_reject pulses; coin_code 0 -> coin_reject.
- Reset asserted in the VEND cycle -> next cycle credit 0, no change_valid, stock reloaded to 8. With VEND_MULTI_CREDIT_EN and credit 30: two selections give two vends and no change_valid.

Source files
------------

// File: rtl/vend_ctrl_multi_if.sv
// Front-end <-> vending controller bus.
// Parameters : CREDIT_W (credit/change width), NUM_ITEMS (product count).
// master : coin acceptor / keypad side, drives coin_valid, coin_code, sel_valid, sel_id, cancel;
//          observes coin_reject, sel_nack, vend_valid, vend_id, change_valid, change_amt, credit, sold_out.
// slave  : controller side, the mirror image of master.
interface vend_ctrl_multi_if #(
    parameter int unsigned CREDIT_W  = 8,
    parameter int unsigned NUM_ITEMS = 4
);
    localparam int unsigned IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;

    logic                 coin_valid;
    logic [1:0]           coin_code;
    logic                 sel_valid;
    logic [IW-1:0]        sel_id;
    logic                 cancel;
    logic                 coin_reject;
    logic                 sel_nack;
    logic                 vend_valid;
    logic [IW-1:0]        vend_id;
    logic                 change_valid;
    logic [CREDIT_W-1:0]  change_amt;
    logic [CREDIT_W-1:0]  credit;
    logic [NUM_ITEMS-1:0] sold_out;

    modport master (
        output coin_valid, coin_code, sel_valid, sel_id, cancel,
        input  coin_reject, sel_nack, vend_valid, vend_id,
        input  change_valid, change_amt, credit, sold_out
    );

    modport slave (
        input  coin_valid, coin_code, sel_valid, sel_id, cancel,
        output coin_reject, sel_nack, vend_valid, vend_id,
        output change_valid, change_amt, credit, sold_out
    );
endinterface

// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: accumulates coin credit, sells NUM_ITEMS
// products at a common PRICE, tracks per-item stock, pays change and refunds.
// Ports: clk, reset (synchronous, active-high), bus (vend_ctrl_multi_if.slave).
// All bus outputs are registered; sold_out is derived from the next stock value.
// Optional feature macro VEND_MULTI_CREDIT_EN: leftover credit after a vend is
// kept (return to CREDIT) instead of being refunded through CHANGE.
module vend_ctrl_multi #(
    parameter int unsigned CREDIT_W   = 8,
    parameter int unsigned NUM_ITEMS  = 4,
    parameter int unsigned STOCK_W    = 4,
    parameter int unsigned STOCK_INIT = 8,
    parameter int unsigned PRICE      = 15,
    parameter int unsigned MAX_CREDIT = 95,
    parameter int unsigned COIN1_VAL  = 5,
    parameter int unsigned COIN2_VAL  = 10,
    parameter int unsigned COIN3_VAL  = 25
) (
    input logic               clk,
    input logic               reset,
    vend_ctrl_multi_if.slave  bus
);
    localparam int unsigned IW    = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1;
    localparam int unsigned SUM_W = CREDIT_W + 1;

    if (longint'(MAX_CREDIT) >= (64'd1 << CREDIT_W)) begin : g_bad_max
        $error("MAX_CREDIT does not fit in CREDIT_W bits");
    end
    if (PRICE > MAX_CREDIT) begin : g_bad_price
        $error("PRICE exceeds MAX_CREDIT");
    end

    typedef enum logic [1:0] {S_IDLE, S_CREDIT, S_VEND, S_CHANGE} state_t;

    state_t               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic                 coin_reject_q, coin_reject_d;
    logic                 sel_nack_q, sel_nack_d;
    logic                 vend_valid_q, vend_valid_d;
    logic [IW-1:0]        vend_id_q, vend_id_d;
    logic                 change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]  change_amt_q, change_amt_d;
    logic [NUM_ITEMS-1:0] sold_out_q, sold_out_d;

    logic [CREDIT_W-1:0]  coin_val;
    logic [SUM_W-1:0]     credit_sum;
    logic                 coin_ok;
    logic                 sel_in_range;
    logic                 sel_ok;

    // Coin decode and acceptance; a coin loses to a cancel or select in the same cycle.
    always_comb begin
        coin_val = '0;
        case (bus.coin_code)
            2'd1:    coin_val = CREDIT_W'(COIN1_VAL);
            2'd2:    coin_val = CREDIT_W'(COIN2_VAL);
            2'd3:    coin_val = CREDIT_W'(COIN3_VAL);
            default: coin_val = '0;
        endcase
        credit_sum = SUM_W'(credit_q) + SUM_W'(coin_val);
        coin_ok    = bus.coin_valid && !bus.cancel && !bus.sel_valid &&
                     (bus.coin_code != 2'd0) && (credit_sum <= SUM_W'(MAX_CREDIT));
    end

    // Selection is only possible with credit on hand (never from IDLE).
    always_comb begin
        sel_in_range = 32'(bus.sel_id) < NUM_ITEMS;
        sel_ok       = (state_q == S_CREDIT) && sel_in_range &&
                       (credit_q >= CREDIT_W'(PRICE)) &&
                       (stock_q[bus.sel_id] != '0);
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_d        = stock_q;
        coin_reject_d  = 1'b0;
        sel_nack_d     = 1'b0;
        vend_valid_d   = 1'b0;
        vend_id_d      = vend_id_q;
        change_valid_d = 1'b0;
        change_amt_d   = change_amt_q;
        sold_out_d     = '0;

        case (state_q)
            S_IDLE, S_CREDIT: begin
                if (bus.cancel) begin
                    if (state_q == S_CREDIT) begin
                        state_d        = S_CHANGE;
                        change_valid_d = 1'b1;
                        change_amt_d   = credit_q;
                        credit_d       = '0;
                    end
                end else if (bus.sel_valid) begin
                    if (sel_ok) begin
                        state_d             = S_VEND;
                        vend_valid_d        = 1'b1;
                        vend_id_d           = bus.sel_id;
                        credit_d            = credit_q - CREDIT_W'(PRICE);
                        stock_d[bus.sel_id] = stock_q[bus.sel_id] - STOCK_W'(1);
                    end else begin
                        sel_nack_d = 1'b1;
                    end
                end else if (coin_ok) begin
                    state_d  = S_CREDIT;
                    credit_d = credit_q + coin_val;
                end
                coin_reject_d = bus.coin_valid && !coin_ok;
            end
            S_VEND: begin
                coin_reject_d = bus.coin_valid;
                if (credit_q == '0) begin
                    state_d = S_IDLE;
                end else begin
`ifdef VEND_MULTI_CREDIT_EN
                    state_d = S_CREDIT;
`else
                    state_d        = S_CHANGE;
                    change_valid_d = 1'b1;
                    change_amt_d   = credit_q;
                    credit_d       = '0;
`endif
                end
            end
            S_CHANGE: begin
                coin_reject_d = bus.coin_valid;
                state_d       = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    // State and output registers; reset discards credit and reloads stock.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            coin_reject_q  <= 1'b0;
            sel_nack_q     <= 1'b0;
            vend_valid_q   <= 1'b0;
            vend_id_q      <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            sold_out_q     <= '0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_q        <= stock_d;
            coin_reject_q  <= coin_reject_d;
            sel_nack_q     <= sel_nack_d;
            vend_valid_q   <= vend_valid_d;
            vend_id_q      <= vend_id_d;
            change_valid_q <= change_valid_d;
            change_amt_q   <= change_amt_d;
            sold_out_q     <= sold_out_d;
        end
    end

    assign bus.coin_reject  = coin_reject_q;
    assign bus.sel_nack     = sel_nack_q;
    assign bus.vend_valid   = vend_valid_q;
    assign bus.vend_id      = vend_id_q;
    assign bus.change_valid = change_valid_q;
    assign bus.change_amt   = change_amt_q;
    assign bus.credit       = credit_q;
    assign bus.sold_out     = sold_out_q;
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Directed self-checking bench for vend_ctrl_multi (default parameters:
// coins 5/10/25, PRICE 15, MAX_CREDIT 95, 4 items with stock 8).
module tb_vend_ctrl_multi;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    vend_ctrl_multi_if #(.CREDIT_W(8), .NUM_ITEMS(4)) bus ();

    vend_ctrl_multi dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Apply one cycle of inputs, then sample just after the capturing edge.
    task automatic cyc(input logic cv, input logic [1:0] cc, input logic sv,
                       input logic [1:0] id, input logic cn);
        bus.coin_valid = cv;
        bus.coin_code  = cc;
        bus.sel_valid  = sv;
        bus.sel_id     = id;
        bus.cancel     = cn;
        @(posedge clk);
        #1;
        bus.coin_valid = 1'b0;
        bus.coin_code  = 2'd0;
        bus.sel_valid  = 1'b0;
        bus.sel_id     = 2'd0;
        bus.cancel     = 1'b0;
    endtask

    task automatic idle();
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.credit !== 8'd0) begin failures++; $display("FAIL reset_credit got=%0d exp=0", bus.credit); end
        checks++; if (bus.vend_valid !== 1'b0) begin failures++; $display("FAIL reset_vend_valid got=%b exp=0", bus.vend_valid); end
        checks++; if (bus.change_valid !== 1'b0) begin failures++; $display("FAIL reset_change_valid got=%b exp=0", bus.change_valid); end
        checks++; if (bus.coin_reject !== 1'b0 || bus.sel_nack !== 1'b0) begin failures++; $display("FAIL reset_pulses got=%b%b exp=00", bus.coin_reject, bus.sel_nack); end
        checks++; if (bus.vend_id !== 2'd0 || bus.change_amt !== 8'd0) begin failures++; $display("FAIL reset_ids got=%0d/%0d exp=0/0", bus.vend_id, bus.change_amt); end
        checks++; if (bus.sold_out !== 4'b0000) begin failures++; $display("FAIL reset_sold_out got=%b exp=0000", bus.sold_out); end
    endtask

    task automatic test_basic_vend();
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.credit !== 8'd10) begin failures++; $display("FAIL basic_credit10 got=%0d exp=10", bus.credit); end
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.credit !== 8'd15) begin failures++; $display("FAIL basic_credit15 got=%0d exp=15", bus.credit); end
        cyc(1'b0, 2'd0, 1'b1, 2'd2, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd2) begin failures++; $display("FAIL basic_vend got=%b id=%0d exp=1 id=2", bus.vend_valid, bus.vend_id); end
        checks++; if (bus.credit !== 8'd0 || bus.sel_nack !== 1'b0) begin failures++; $display("FAIL basic_vend_credit got=%0d nack=%b exp=0 nack=0", bus.credit, bus.sel_nack); end
        idle();
        checks++; if (bus.vend_valid !== 1'b0 || bus.change_valid !== 1'b0) begin failures++; $display("FAIL basic_after got=%b%b exp=00", bus.vend_valid, bus.change_valid); end
        checks++; if (dut.stock_q[2] !== 4'd7) begin failures++; $display("FAIL basic_stock2 got=%0d exp=7", dut.stock_q[2]); end
        idle();
        checks++; if (bus.change_valid !== 1'b0 || bus.credit !== 8'd0) begin failures++; $display("FAIL basic_idle got=%b credit=%0d exp=0 credit=0", bus.change_valid, bus.credit); end
    endtask

    task automatic test_change();
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.credit !== 8'd25) begin failures++; $display("FAIL change_credit25 got=%0d exp=25", bus.credit); end
        cyc(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd0 || bus.credit !== 8'd10) begin failures++; $display("FAIL change_vend got=%b id=%0d credit=%0d exp=1 id=0 credit=10", bus.vend_valid, bus.vend_id, bus.credit); end
        idle();
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd10) begin failures++; $display("FAIL change_pulse got=%b amt=%0d exp=1 amt=10", bus.change_valid, bus.change_amt); end
        checks++; if (bus.credit !== 8'd0 || bus.vend_valid !== 1'b0) begin failures++; $display("FAIL change_credit0 got=%0d vend=%b exp=0 vend=0", bus.credit, bus.vend_valid); end
        idle();
        checks++; if (bus.change_valid !== 1'b0) begin failures++; $display("FAIL change_one_cycle got=%b exp=0", bus.change_valid); end
        cyc(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        checks++; if (bus.sel_nack !== 1'b1 || bus.vend_valid !== 1'b0) begin failures++; $display("FAIL idle_select_nack got=%b vend=%b exp=1 vend=0", bus.sel_nack, bus.vend_valid); end
    endtask

    task automatic test_max_credit();
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
            checks++; if (bus.credit !== 8'(25 * k)) begin failures++; $display("FAIL max_accum%0d got=%0d exp=%0d", k, bus.credit, 25 * k); end
        end
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd75) begin failures++; $display("FAIL max_reject got=%b credit=%0d exp=1 credit=75", bus.coin_reject, bus.credit); end
        idle();
        checks++; if (bus.coin_reject !== 1'b0) begin failures++; $display("FAIL max_reject_pulse got=%b exp=0", bus.coin_reject); end
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd75 || bus.credit !== 8'd0) begin failures++; $display("FAIL cancel75 got=%b amt=%0d credit=%0d exp=1 amt=75 credit=0", bus.change_valid, bus.change_amt, bus.credit); end
        idle();
        // Land exactly on the ceiling, then overshoot by the smallest coin.
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.credit !== 8'd95 || bus.coin_reject !== 1'b0) begin failures++; $display("FAIL max_exact got=%0d rej=%b exp=95 rej=0", bus.credit, bus.coin_reject); end
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd95) begin failures++; $display("FAIL max_over got=%b credit=%0d exp=1 credit=95", bus.coin_reject, bus.credit); end
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd95) begin failures++; $display("FAIL cancel95 got=%b amt=%0d exp=1 amt=95", bus.change_valid, bus.change_amt); end
        idle();
    endtask

    task automatic test_sold_out();
        for (int k = 0; k < 8; k++) begin
            cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
            cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
            cyc(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
            checks++; if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd1) begin failures++; $display("FAIL drain%0d got=%b id=%0d exp=1 id=1", k, bus.vend_valid, bus.vend_id); end
            idle();
        end
        checks++; if (bus.sold_out !== 4'b0010) begin failures++; $display("FAIL sold_out got=%b exp=0010", bus.sold_out); end
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        checks++; if (bus.sel_nack !== 1'b1 || bus.vend_valid !== 1'b0 || bus.credit !== 8'd15) begin failures++; $display("FAIL sold_out_nack got=%b vend=%b credit=%0d exp=1 vend=0 credit=15", bus.sel_nack, bus.vend_valid, bus.credit); end
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd15) begin failures++; $display("FAIL sold_out_refund got=%b amt=%0d exp=1 amt=15", bus.change_valid, bus.change_amt); end
        idle();
    endtask

    task automatic test_priority();
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd2, 1'b1, 2'd0, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.coin_reject !== 1'b1 || bus.credit !== 8'd0) begin failures++; $display("FAIL prio_sel_over_coin got=%b rej=%b credit=%0d exp=1 rej=1 credit=0", bus.vend_valid, bus.coin_reject, bus.credit); end
        idle();
        cyc(1'b1, 2'd0, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.coin_reject !== 1'b1 || bus.credit !== 8'd0) begin failures++; $display("FAIL coin_code0 got=%b credit=%0d exp=1 credit=0", bus.coin_reject, bus.credit); end
        cyc(1'b0, 2'd0, 1'b0, 2'd0, 1'b1);
        checks++; if (bus.change_valid !== 1'b0 || bus.credit !== 8'd0) begin failures++; $display("FAIL idle_cancel got=%b credit=%0d exp=0 credit=0", bus.change_valid, bus.credit); end
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 2'd3, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd3) begin failures++; $display("FAIL prio_vend3 got=%b id=%0d exp=1 id=3", bus.vend_valid, bus.vend_id); end
        cyc(1'b1, 2'd1, 1'b1, 2'd0, 1'b0);
        checks++; if (bus.coin_reject !== 1'b1 || bus.sel_nack !== 1'b0 || bus.vend_valid !== 1'b0 || bus.credit !== 8'd0) begin failures++; $display("FAIL busy_inputs got=rej%b nack%b vend%b credit=%0d exp=rej1 nack0 vend0 credit=0", bus.coin_reject, bus.sel_nack, bus.vend_valid, bus.credit); end
        idle();
    endtask

    task automatic test_reset_in_vend();
        cyc(1'b1, 2'd2, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        cyc(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.credit !== 8'd5) begin failures++; $display("FAIL rst_vend_setup got=%b credit=%0d exp=1 credit=5", bus.vend_valid, bus.credit); end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checks++; if (bus.credit !== 8'd0 || bus.change_valid !== 1'b0 || bus.vend_valid !== 1'b0) begin failures++; $display("FAIL rst_vend got=credit%0d chg%b vend%b exp=credit0 chg0 vend0", bus.credit, bus.change_valid, bus.vend_valid); end
        checks++; if (bus.sold_out !== 4'b0000 || dut.stock_q[1] !== 4'd8) begin failures++; $display("FAIL rst_stock got=%b stock1=%0d exp=0000 stock1=8", bus.sold_out, dut.stock_q[1]); end
        idle();
        checks++; if (bus.change_valid !== 1'b0 || bus.credit !== 8'd0) begin failures++; $display("FAIL rst_after got=%b credit=%0d exp=0 credit=0", bus.change_valid, bus.credit); end
    endtask

    task automatic test_multi_credit();
        cyc(1'b1, 2'd3, 1'b0, 2'd0, 1'b0);
        cyc(1'b1, 2'd1, 1'b0, 2'd0, 1'b0);
        checks++; if (bus.credit !== 8'd30) begin failures++; $display("FAIL multi_credit30 got=%0d exp=30", bus.credit); end
        cyc(1'b0, 2'd0, 1'b1, 2'd0, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.credit !== 8'd15) begin failures++; $display("FAIL multi_vend1 got=%b credit=%0d exp=1 credit=15", bus.vend_valid, bus.credit); end
        idle();
`ifdef VEND_MULTI_CREDIT_EN
        checks++; if (bus.change_valid !== 1'b0 || bus.credit !== 8'd15) begin failures++; $display("FAIL multi_keep got=%b credit=%0d exp=0 credit=15", bus.change_valid, bus.credit); end
        cyc(1'b0, 2'd0, 1'b1, 2'd1, 1'b0);
        checks++; if (bus.vend_valid !== 1'b1 || bus.vend_id !== 2'd1 || bus.credit !== 8'd0) begin failures++; $display("FAIL multi_vend2 got=%b id=%0d credit=%0d exp=1 id=1 credit=0", bus.vend_valid, bus.vend_id, bus.credit); end
        idle();
        checks++; if (bus.change_valid !== 1'b0) begin failures++; $display("FAIL multi_no_change got=%b exp=0", bus.change_valid); end
`else
        checks++; if (bus.change_valid !== 1'b1 || bus.change_amt !== 8'd15 || bus.credit !== 8'd0) begin failures++; $display("FAIL refund15 got=%b amt=%0d credit=%0d exp=1 amt=15 credit=0", bus.change_valid, bus.change_amt, bus.credit); end
        idle();
`endif
    endtask

    initial begin
        bus.coin_valid = 1'b0;
        bus.coin_code  = 2'd0;
        bus.sel_valid  = 1'b0;
        bus.sel_id     = 2'd0;
        bus.cancel     = 1'b0;
        test_reset();
        test_basic_vend();
        test_change();
        test_max_credit();
        test_sold_out();
        test_priority();
        test_reset_in_vend();
        test_multi_credit();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
